// File: rtl/mem_if_pkg.sv
// Shared encodings for the bus-side memory stage: request types, access sizes,
// AXI response codes and the transaction state machine states.
package mem_if_pkg;

  typedef enum logic [1:0] {
    WR_STORE = 2'b00,
    WR_LOAD  = 2'b01,
    WR_RSVD  = 2'b10,
    WR_FETCH = 2'b11
  } wr_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } sz_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_RESP,
    ST_DONE,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/mem_interface_axi_lane_align.sv
// Byte-lane steering shared by the read and write paths: load lane select with
// sign/zero extension, store data replication and write strobes.
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  sz_e         size,
  input  logic        sign,
  input  logic [31:0] rdata_i,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata_i[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_data = rdata_i;
    wdata_o   = store_data;
    wstrb     = '0;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign & byte_sel[7]}}, byte_sel};
        wdata_o   = {4{store_data[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        load_data = {{16{sign & half_sel[15]}}, half_sel};
        wdata_o   = {2{store_data[15:0]}};
        wstrb     = 4'b0011 << addr_lo;
      end
      SZ_WORD: begin
        wstrb = '1;
      end
      default: begin
        // Reserved size always faults before reaching the bus.
        wstrb = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_interface_axi.sv
// Memory stage between the core control FSM and an AXI4-Lite bus: one request
// in, one single-beat AXI transaction out, with alignment checking and extension.
module mem_interface_axi
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [2:0]  PROT_FETCH = 3'b100,
  parameter logic [2:0]  PROT_DATA  = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_mem,
  input  logic [1:0]            W_R_mem,
  input  logic [1:0]            wordsize_mem,
  input  logic                  sign_mem,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy_mem,
  output logic                  done_mem,
  output logic                  aligned_mem,
  output logic [31:0]           rdata,
  output logic [31:0]           inst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata_i,
  input  logic [1:0]            rresp
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [31:0]           req_wdata_q, req_wdata_d;
  wr_e                   req_wr_q, req_wr_d;
  sz_e                   req_size_q, req_size_d;
  logic                  req_sign_q, req_sign_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           inst_q, inst_d;

  logic        is_fetch;
  logic        is_store;
  sz_e         eff_size;
  logic        misaligned;
  logic        aw_now;
  logic        w_now;
  logic [31:0] load_ext;
  logic        unused_resp;

  // Responses are deliberately not inspected.
  assign unused_resp = ^{bresp, rresp};

  assign is_fetch = (req_wr_q == WR_FETCH);
  assign is_store = (req_wr_q == WR_STORE);
  assign eff_size = is_fetch ? SZ_WORD : req_size_q;

  assign misaligned = (eff_size == SZ_RSVD)
                   || ((eff_size == SZ_HALF) && req_addr_q[0])
                   || ((eff_size == SZ_WORD) && (req_addr_q[1:0] != 2'b00));

  assign araddr = {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign awaddr = {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign arprot = is_fetch ? PROT_FETCH : PROT_DATA;
  assign awprot = PROT_DATA;
  assign rdata  = rdata_q;
  assign inst   = inst_q;

  mem_lane_align u_lane_align (
    .addr_lo    (req_addr_q[1:0]),
    .size       (eff_size),
    .sign       (req_sign_q),
    .rdata_i    (rdata_i),
    .store_data (req_wdata_q),
    .load_data  (load_ext),
    .wdata_o    (wdata_o),
    .wstrb      (wstrb)
  );

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_sign_d  = req_sign_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rdata_d     = rdata_q;
    inst_d      = inst_q;
    aw_now      = 1'b0;
    w_now       = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    busy_mem    = 1'b0;
    done_mem    = 1'b0;
    aligned_mem = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (en_mem) begin
          req_addr_d  = addr;
          req_wdata_d = wdata;
          req_wr_d    = wr_e'(W_R_mem);
          req_size_d  = sz_e'(wordsize_mem);
          req_sign_d  = sign_mem;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        busy_mem  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (misaligned)    state_d = ST_FAULT;
        else if (is_store) state_d = ST_WR_ADDR;
        else               state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        busy_mem = 1'b1;
        arvalid  = 1'b1;
        if (arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        busy_mem = 1'b1;
        rready   = 1'b1;
        if (rvalid) begin
          if (is_fetch) inst_d  = load_ext;
          else          rdata_d = load_ext;
          state_d = ST_DONE;
        end
      end
      ST_WR_ADDR: begin
        // AW and W complete independently; move on once both have handshaken.
        busy_mem  = 1'b1;
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_now    = aw_done_q | awready;
        w_now     = w_done_q | wready;
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        busy_mem = 1'b1;
        bready   = 1'b1;
        if (bvalid) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_mem = 1'b1;
        done_mem = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_FAULT: begin
        aligned_mem = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wr_q    <= WR_STORE;
      req_size_q  <= SZ_BYTE;
      req_sign_q  <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rdata_q     <= '0;
      inst_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_sign_q  <= req_sign_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rdata_q     <= rdata_d;
      inst_q      <= inst_d;
    end
  end

endmodule

// File: doc/mem_interface_axi.md
Name: mem_interface_axi

Overview:
- Bus-side memory stage directly downstream of the core control FSM.
- Accepts a one-cycle en_mem request (fetch, load or store), then runs a single AXI4-Lite master transaction.
- Aligns load data and sign- or zero-extends it, and generates store byte strobes.
- Returns busy_mem, done_mem and aligned_mem to the control FSM, and delivers the fetched instruction or load data to the datapath.

Parameters:
ADDR_WIDTH, 32, width of addr and the AXI address buses
PROT_FETCH, 3'b100, value driven on arprot for instruction fetches
PROT_DATA, 3'b000, value driven on arprot/awprot for loads and stores

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
en_mem  in  1  request strobe; sampled only in IDLE
W_R_mem  in  2  00 store, 01 load, 11 fetch, 10 reserved (handled as load)
wordsize_mem  in  2  00 byte, 01 half, 10 word, 11 reserved (misaligned); ignored for fetch (word forced)
sign_mem  in  1  1 = sign-extend load, 0 = zero-extend
addr  in  ADDR_WIDTH  byte address; captured with en_mem
wdata  in  32  store data in LSBs; captured with en_mem
busy_mem  out  1  transaction in progress
done_mem  out  1  one-cycle completion pulse
aligned_mem  out  1  0 = misaligned or reserved request seen (sticky)
rdata  out  32  extended load data; held until the next load completes
inst  out  32  fetched instruction; held until the next fetch completes
awvalid/awready/awaddr/awprot, wvalid/wready/wdata_o/wstrb, bvalid/bready/bresp, arvalid/arready/araddr/arprot, rvalid/rready/rdata_i/rresp  AXI4-Lite master channels (32-bit data)

Behaviour:
- Reset values (asserted at any time, including mid-transaction):
  - Outputs: all AXI valid/ready = 0; busy_mem = 0; done_mem = 0; aligned_mem = 1; rdata = 0; inst = 0.
  - State: IDLE.
  - Any outstanding bus transaction is abandoned.
- States: IDLE, CHECK, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE, FAULT.
- IDLE:
  - en_mem = 1 captures addr, wdata, W_R_mem, wordsize_mem and sign_mem into request registers.
  - Then goes to CHECK.
- CHECK (busy_mem = 1 from here until DONE inclusive):
  - Misaligned when any of: size = half with addr[0] = 1; size = word (or fetch) with addr[1:0] != 0; size = 11.
  - Misaligned -> FAULT. Otherwise -> RD_ADDR for load/fetch, WR_ADDR for store.
- RD_ADDR:
  - arvalid = 1 and araddr = {addr[31:2], 2'b00}.
  - On arready, drop arvalid and go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, lane-select by addr[1:0], extend per size and sign, write to rdata (load) or inst (fetch), then go to DONE.
- WR_ADDR:
  - awvalid and wvalid both assert together; each drops independently on its own ready.
  - Leave for WR_RESP once both handshakes have completed, in either order or in the same cycle.
  - wdata_o = store data replicated to all lanes (byte: 4 copies; half: 2 copies).
  - wstrb: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
- WR_RESP:
  - bready = 1.
  - On bvalid, go to DONE.
- DONE:
  - done_mem = 1 for exactly this cycle; busy_mem = 1.
  - Next state is IDLE.
- FAULT:
  - aligned_mem = 0 and busy_mem = 0; no bus traffic; done_mem is never pulsed.
  - Exit only by reset.
- en_mem is ignored outside IDLE; no queueing.
- bresp/rresp are ignored; data is accepted regardless.
- Minimum latency with ready/valid already high: en_mem at cycle 0, valid at cycle 2, done_mem at cycle 4.
  - Each stall cycle on a ready or valid adds one cycle.
- Extension rules:
  - Byte: bits [7:0] of the selected lane; upper bits = sign ? bit7 : 0.
  - Half: lane pair addr[1]; upper bits = sign ? bit15 : 0.

Decomposition:
- mem_if_pkg holds:
  - W_R encodings (WR_STORE, WR_LOAD, WR_FETCH).
  - Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - The state enum.
  - AXI_RESP_OKAY.
- One sub-module, mem_lane_align: purely combinational.
  - Inputs: addr[1:0], size, sign, rdata_i, store data.
  - Outputs: extended load data, wdata_o, wstrb.
  - Reused by both read and write paths.

Test Plan:
- Fetch at 0x100, arready and rvalid held high, rdata_i = 0x00A00093 -> araddr = 0x100, arprot = 3'b100, done_mem at cycle 4, inst = 0x00A00093, rdata unchanged.
- Signed byte load at 0x203, rdata_i = 0x80FF7F01 -> rdata = 0xFFFFFF80; the same load with sign = 0 -> rdata = 0x00000080.
- Half store at 0x302 of 0x0000BEEF, wready 3 cycles after awready -> wdata_o = 0xBEEFBEEF, wstrb = 4'b1100, done_mem one cycle after the bvalid handshake, busy_mem high throughout.
- Word load at 0x401 -> no arvalid ever, aligned_mem falls in the cycle after CHECK and stays 0, done_mem stays 0 for 20 cycles; reset -> aligned_mem = 1.
- Reset asserted while in RD_DATA with rvalid low -> all valid/ready, busy_mem and done_mem go to 0 asynchronously; a following fetch completes normally.
- en_mem pulsed again while busy (store in WR_RESP) -> ignored, exactly one done_mem pulse and one AW handshake.
